// File: rtl/min_uint8_stream.sv
// Streaming packet minimum: min (and optionally argmin) of each in_last-terminated packet.
// Optional argmin output/index tracking enabled by `define MIN_UINT8_STREAM_ARGMIN_EN.

module lt_uint_nbit #(
    parameter int WIDTH     = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             y
);
    generate
        if (IMPL_TYPE == 0) begin : g_direct
            assign y = (a < b);
        end else begin : g_ripple
            // Scan LSB->MSB; the most significant differing bit overwrites the earlier ones.
            always_comb begin
                y = 1'b0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (a[i] != b[i]) y = b[i];
                end
            end
        end
    endgenerate
endmodule

module min_uint8_stream #(
    parameter int WIDTH     = 8,
    parameter int IMPL_TYPE = 0,
    parameter int IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min
`ifdef MIN_UINT8_STREAM_ARGMIN_EN
    ,
    output logic [IDX_W-1:0] out_idx
`endif
);

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_ACC   = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] out_min_q, out_min_d;
    logic             accept;
    logic             lt_y;

    lt_uint_nbit #(
        .WIDTH    (WIDTH),
        .IMPL_TYPE(IMPL_TYPE)
    ) u_lt (
        .a(in_data),
        .b(min_q),
        .y(lt_y)
    );

    assign in_ready  = (state_q != S_OUT);
    assign out_valid = (state_q == S_OUT);
    assign out_min   = out_min_q;
    assign accept    = in_valid && in_ready;

`ifdef MIN_UINT8_STREAM_ARGMIN_EN
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;

    assign out_idx = out_idx_q;
`endif

    // NOTE: every always_comb target gets its default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        out_min_d = out_min_q;
`ifdef MIN_UINT8_STREAM_ARGMIN_EN
        idx_d     = idx_q;
        count_d   = count_q;
        out_idx_d = out_idx_q;
`endif
        case (state_q)
            S_FIRST: begin
                if (accept) begin
                    min_d = in_data;
`ifdef MIN_UINT8_STREAM_ARGMIN_EN
                    idx_d   = '0;
                    count_d = IDX_W'(1);
`endif
                    if (in_last) begin
                        state_d   = S_OUT;
                        out_min_d = in_data;
`ifdef MIN_UINT8_STREAM_ARGMIN_EN
                        out_idx_d = '0;
`endif
                    end else begin
                        state_d = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (accept) begin
                    // Strict less-than: equal values keep the earlier position.
                    if (lt_y) min_d = in_data;
`ifdef MIN_UINT8_STREAM_ARGMIN_EN
                    if (lt_y) idx_d = count_q;
                    count_d = count_q + 1'b1;
`endif
                    if (in_last) begin
                        state_d   = S_OUT;
                        out_min_d = lt_y ? in_data : min_q;
`ifdef MIN_UINT8_STREAM_ARGMIN_EN
                        out_idx_d = lt_y ? count_q : idx_q;
`endif
                    end
                end
            end
            S_OUT: begin
                if (out_ready) state_d = S_FIRST;
            end
            default: state_d = S_FIRST;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FIRST;
            min_q     <= '0;
            out_min_q <= '0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            out_min_q <= out_min_d;
        end
    end

`ifdef MIN_UINT8_STREAM_ARGMIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            count_q   <= '0;
            out_idx_q <= '0;
        end else begin
            idx_q     <= idx_d;
            count_q   <= count_d;
            out_idx_q <= out_idx_d;
        end
    end
`endif

endmodule
